mem_arbiter: RTL

//   Two-port round-robin arbiter that shares one single-port synchronous RAM
//   (1-cycle registered read, read-before-write) between two requesters,
//   e.g. CPU (port 0) and I/O/DMA (port 1). Sits between the requesters and
//   the RAM, serialising accesses and routing read data back to the winner.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters; one access every three cycles, read data routed to the winner.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  // state | meaning
  // IDLE  | no access in flight; arbitrate on req0/req1
  // ISSUE | gnt pulse high; RAM samples mem_* at the end of this cycle
  // RESP  | mem_out valid; captured into the winner's rdata
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   last;
  logic   pick;

  // Tie goes to the port that did not win last; last also names the owner in flight.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last;
    else if (req1)    pick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      busy     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (req0 || req1) begin
            last     <= pick;
            gnt0     <= ~pick;
            gnt1     <= pick;
            mem_we   <= pick ? we1 : we0;
            mem_addr <= pick ? addr1 : addr0;
            mem_data <= pick ? wdata1 : wdata0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (last) begin
            rdata1  <= mem_out;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_out;
            rvalid0 <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
